// File: rtl/uart_tx_fifo_if.sv
// Byte-stream handshake and serial line of the buffered UART transmitter.
// master = producer side, slave = transmitter side.
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       busy;
    logic       UART_TX;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, busy, UART_TX
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, busy, UART_TX
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; back-to-back frames are sent with no idle gap.
// UART_TX and tx_done are registered, so they trail the FSM state by one cycle.
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIV   = 5208,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic           sysclk,
    input logic           reset,
    uart_tx_fifo_if.slave bus
);

    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          line_q, line_d;
    logic          done_q, done_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic ready, push, pop, baud_last, fifo_nonempty;

    assign ready         = count_q < CW'(FIFO_DEPTH);
    assign push          = bus.tx_valid && ready;
    assign fifo_nonempty = count_q != '0;
    assign baud_last     = baud_q == BW'(BAUD_DIV - 1);

    assign bus.tx_ready = ready;
    assign bus.tx_done  = done_q;
    assign bus.busy     = (state_q != StIdle) || fifo_nonempty;
    assign bus.UART_TX  = line_q;

    // Storage needs no reset: the pointers and count define validity.
    always_ff @(posedge sysclk) begin
        if (push) mem_q[wr_ptr_q] <= bus.tx_data;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        line_d  = 1'b1;
        done_d  = 1'b0;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                line_d = 1'b0;
                baud_d = baud_last ? '0 : baud_q + BW'(1);
                if (baud_last) state_d = StData;
            end
            StData: begin
                line_d = shift_q[0];
                baud_d = baud_last ? '0 : baud_q + BW'(1);
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            StStop: begin
                line_d = 1'b1;
                baud_d = baud_last ? '0 : baud_q + BW'(1);
                if (baud_last) begin
                    done_d = 1'b1;
                    // Chain straight into the next start bit when more data is queued.
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        bit_d   = '0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a fast instance (BAUD_DIV=4) for framing, FIFO and reset
// behaviour, and a default-parameter instance for the full-rate 0x00 frame.
module tb_uart_tx_fifo;

    localparam int B = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_if bus4 ();
    uart_tx_fifo_if busd ();

    uart_tx_fifo #(.BAUD_DIV(B), .FIFO_DEPTH(4)) dut (
        .sysclk(clk),
        .reset (rst_n),
        .bus   (bus4)
    );

    uart_tx_fifo dut_def (
        .sysclk(clk),
        .reset (rst_n),
        .bus   (busd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one 10-bit frame cycle by cycle. contig=1: start bit must begin at the next sample.
    task automatic rx_frame(input logic [7:0] b, input bit contig, input string tag);
        logic [9:0] bits;
        int n;
        bits = {1'b1, b, 1'b0};
        n = 0;
        if (contig) @(negedge clk);
        else begin
            while (bus4.UART_TX !== 1'b0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        for (int k = 0; k < 10 * B; k++) begin
            if (k > 0) @(negedge clk);
            check({tag, " line"}, {31'd0, bus4.UART_TX}, {31'd0, bits[k / B]});
            check({tag, " done"}, {31'd0, bus4.tx_done}, {31'd0, k == 10 * B - 1});
        end
    endtask

    task automatic idle_line(input int cycles, input string tag);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus4.UART_TX !== 1'b1 || bus4.tx_done !== 1'b0) lows++;
        end
        check(tag, lows, 0);
    endtask

    initial begin
        logic [5:0] exp_rdy;
        int n, lows, highs;

        rst_n         = 1'b0;
        bus4.tx_valid = 1'b0;
        bus4.tx_data  = 8'h00;
        busd.tx_valid = 1'b0;
        busd.tx_data  = 8'h00;
        repeat (3) @(negedge clk);

        check("rst line",  {31'd0, bus4.UART_TX},  32'd1);
        check("rst done",  {31'd0, bus4.tx_done},  32'd0);
        check("rst busy",  {31'd0, bus4.busy},     32'd0);
        check("rst ready", {31'd0, bus4.tx_ready}, 32'd1);
        check("rst line def", {31'd0, busd.UART_TX}, 32'd1);

        // Single 0x35 frame; push lands on the first edge after reset release.
        rst_n         = 1'b1;
        bus4.tx_valid = 1'b1;
        bus4.tx_data  = 8'h35;
        @(negedge clk);
        check("t1 busy", {31'd0, bus4.busy}, 32'd1);
        check("t1 line N", {31'd0, bus4.UART_TX}, 32'd1);
        bus4.tx_valid = 1'b0;
        bus4.tx_data  = 8'hCA;
        @(negedge clk);
        check("t1 line N+1", {31'd0, bus4.UART_TX}, 32'd1);
        rx_frame(8'h35, 1'b1, "t1");
        check("t1 busy end", {31'd0, bus4.busy}, 32'd0);
        idle_line(2 * B, "t1 idle");

        // Three back-to-back bytes.
        bus4.tx_valid = 1'b1;
        bus4.tx_data  = 8'hA5;
        @(negedge clk);
        bus4.tx_data  = 8'h3C;
        @(negedge clk);
        bus4.tx_data  = 8'hFF;
        @(negedge clk);
        bus4.tx_valid = 1'b0;
        bus4.tx_data  = 8'h00;
        rx_frame(8'hA5, 1'b0, "t2 f0");
        rx_frame(8'h3C, 1'b1, "t2 f1");
        rx_frame(8'hFF, 1'b1, "t2 f2");
        check("t2 busy end", {31'd0, bus4.busy}, 32'd0);
        repeat (2) @(negedge clk);

        // Six offers with tx_valid held; the sixth meets a full FIFO.
        exp_rdy = 6'b011111;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    bus4.tx_valid = 1'b1;
                    bus4.tx_data  = 8'(8'h11 + i);
                    check("t3 ready", {31'd0, bus4.tx_ready}, {31'd0, exp_rdy[i]});
                    @(negedge clk);
                end
                bus4.tx_valid = 1'b0;
                check("t3 ready full", {31'd0, bus4.tx_ready}, 32'd0);
            end
            begin
                rx_frame(8'h11, 1'b0, "t3 f0");
                rx_frame(8'h12, 1'b1, "t3 f1");
                rx_frame(8'h13, 1'b1, "t3 f2");
                rx_frame(8'h14, 1'b1, "t3 f3");
                rx_frame(8'h15, 1'b1, "t3 f4");
                idle_line(2 * B, "t3 dropped absent");
                check("t3 busy end", {31'd0, bus4.busy}, 32'd0);
            end
        join
        repeat (2) @(negedge clk);

        // Reset during data bit 3 of 0x55 with two bytes queued.
        bus4.tx_valid = 1'b1;
        bus4.tx_data  = 8'h55;
        @(negedge clk);
        bus4.tx_data  = 8'h01;
        @(negedge clk);
        bus4.tx_data  = 8'h02;
        @(negedge clk);
        bus4.tx_valid = 1'b0;
        check("t4 start", {31'd0, bus4.UART_TX}, 32'd0);
        repeat (4 * B + 1) @(negedge clk);
        check("t4 bit3", {31'd0, bus4.UART_TX}, 32'd0);
        check("t4 busy", {31'd0, bus4.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t4 rst line",  {31'd0, bus4.UART_TX},  32'd1);
        check("t4 rst busy",  {31'd0, bus4.busy},     32'd0);
        check("t4 rst ready", {31'd0, bus4.tx_ready}, 32'd1);
        check("t4 rst done",  {31'd0, bus4.tx_done},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_line(25 * B, "t4 no resume");
        check("t4 busy after", {31'd0, bus4.busy}, 32'd0);

        // Offer while full on the same edge as the stop-end pop.
        fork
            begin
                bus4.tx_valid = 1'b1;
                bus4.tx_data  = 8'h81;
                @(negedge clk);
                bus4.tx_data  = 8'h42;
                @(negedge clk);
                bus4.tx_data  = 8'h24;
                @(negedge clk);
                bus4.tx_data  = 8'h18;
                @(negedge clk);
                bus4.tx_data  = 8'hE7;
                @(negedge clk);
                bus4.tx_valid = 1'b0;
                check("t5 full", {31'd0, bus4.tx_ready}, 32'd0);
                repeat (36) @(negedge clk);
                check("t5 full pre", {31'd0, bus4.tx_ready}, 32'd0);
                bus4.tx_valid = 1'b1;
                bus4.tx_data  = 8'h99;
                @(negedge clk);
                check("t5 done align", {31'd0, bus4.tx_done}, 32'd1);
                check("t5 ready after", {31'd0, bus4.tx_ready}, 32'd1);
                bus4.tx_valid = 1'b0;
            end
            begin
                rx_frame(8'h81, 1'b0, "t5 f0");
                rx_frame(8'h42, 1'b1, "t5 f1");
                rx_frame(8'h24, 1'b1, "t5 f2");
                rx_frame(8'h18, 1'b1, "t5 f3");
                rx_frame(8'hE7, 1'b1, "t5 f4");
                idle_line(2 * B, "t5 dropped absent");
            end
        join

        // Default rate: 0x00 gives 9 bit-times low then one high.
        busd.tx_valid = 1'b1;
        busd.tx_data  = 8'h00;
        @(negedge clk);
        busd.tx_valid = 1'b0;
        n = 0;
        while (busd.UART_TX !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        lows = 0;
        while (busd.UART_TX === 1'b0 && lows < 50000) begin
            lows++;
            @(negedge clk);
        end
        check("t6 low cycles", lows, 32'd46872);
        highs = 1;
        while (busd.tx_done !== 1'b1 && highs < 6000) begin
            @(negedge clk);
            highs++;
        end
        check("t6 high cycles", highs, 32'd5208);
        check("t6 busy end", {31'd0, busd.busy}, 32'd0);
        check("t6 line end", {31'd0, busd.UART_TX}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 5208, meaning sysclk cycles per UART bit (50 MHz / 9600 baud).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning byte entries buffered ahead of the shifter (power of two, >= 2).
REQ-003 The block SHALL have port sysclk  input  1  system clock, all state on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port tx_data  input  8  byte to transmit.
REQ-006 The block SHALL have port tx_valid  input  1  producer offers tx_data this cycle.
REQ-007 The block SHALL have port tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 The block SHALL have port tx_done  output  1  one-cycle pulse when a frame's stop bit completes.
REQ-009 The block SHALL have port busy  output  1  frame in progress or FIFO non-empty.
REQ-010 The block SHALL have port UART_TX  output  1  serial line, idle high, registered.

Function
REQ-011 A byte SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1; tx_data is ignored otherwise.
REQ-012 tx_ready SHALL equal (FIFO count < FIFO_DEPTH) from registered count; a push offered while full is dropped, even if a pop occurs the same edge.
REQ-013 A simultaneous push and pop while not full SHALL leave count unchanged and preserve FIFO order.
REQ-014 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-016 IDLE: UART_TX=1; when FIFO non-empty, pop head into shift register, clear baud and bit counters, go to START.
REQ-017 START: UART_TX=0 for exactly BAUD_DIV cycles, then DATA.
REQ-018 DATA: 8 bits LSB first, each held exactly BAUD_DIV cycles; bit counter 0..7; after bit 7 go to STOP.
REQ-019 STOP: UART_TX=1 for exactly BAUD_DIV cycles; on its last cycle assert tx_done for one cycle.
REQ-020 At STOP end, if FIFO non-empty, pop next byte and go directly to START (no idle bit between frames); else go to IDLE.
REQ-021 Every frame SHALL be exactly 10*BAUD_DIV cycles from UART_TX falling edge to end of stop bit.
REQ-022 Latency: byte accepted at edge N into empty FIFO while IDLE SHALL drive UART_TX low after edge N+2.
REQ-023 Baud counter SHALL count 0..BAUD_DIV-1 and wrap; width ceil(log2(BAUD_DIV)).
REQ-024 busy SHALL equal (state != IDLE) OR (count != 0).
REQ-025 tx_data changes after acceptance SHALL not affect any queued or in-flight byte.

Reset
REQ-026 While reset=0: UART_TX=1, tx_done=0, busy=0, tx_ready=1, FSM=IDLE, FIFO empty, counters 0; all take effect asynchronously.
REQ-027 Reset asserted mid-frame SHALL abort the frame and flush the FIFO; after release no partial frame resumes.
REQ-028 First push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-029 BAUD_DIV=4, push 0x35 once -> UART_TX sequence 0,1,0,1,0,1,1,0,0,1, each held 4 cycles; tx_done pulses once at the stop bit's last cycle; busy then 0.
REQ-030 Push 0xA5,0x3C,0xFF back-to-back -> three contiguous 40-cycle frames, no idle gap, 3 tx_done pulses, order preserved.
REQ-031 Push 6 bytes continuously with tx_valid held -> tx_ready drops at count=FIFO_DEPTH; dropped offers absent from line; accepted bytes transmitted in order.
REQ-032 Assert reset during DATA bit 3 of 0x55 with 2 queued -> UART_TX=1 immediately, busy=0, no further frames after release.
REQ-033 Default BAUD_DIV=5208, push 0x00 -> UART_TX low for 9*5208 cycles (start + 8 data) then high 5208 cycles.
REQ-034 Push while full coinciding with STOP-end pop -> offer dropped, count stays FIFO_DEPTH-1 after edge, tx_ready=1 next cycle.
